// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback collector.
// Slot numbering matches the execution units that return results.
package wb_pkg;

  localparam int NUM_SLOTS = 4;

  localparam int SLOT_A0 = 0;
  localparam int SLOT_A1 = 1;
  localparam int SLOT_M  = 2;
  localparam int SLOT_LS = 3;

  localparam int WB_DATA_W = 32;
  localparam int WB_TAG_W  = 6;
  localparam int WB_REG_W  = 5;

  // One buffered result: payload, dest tag and dest register (rd in the low bits).
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_TAG_W-1:0]  tag;
    logic [WB_REG_W-1:0]  rd;
  } wb_entry_t;

endpackage

// File: rtl/wb_slot_fifo.sv
// Single-slot synchronous FIFO holding results from one execution unit.
// Pointers carry one extra wrap bit so full and empty are told apart.
module wb_slot_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Advance pointers on accepted pushes and pops; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers guard them.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_collect.sv
// Collects completed results from the A0/A1/M/LS units and round-robin
// arbitrates them onto two registered writeback ports.
// Optional macro WB_BYPASS_EN lets a result entering an empty slot be
// granted in the same cycle, skipping the FIFO.
module wb_collect import wb_pkg::*; #(
  parameter int DATA_W     = WB_DATA_W,
  parameter int TAG_W      = WB_TAG_W,
  parameter int REG_W      = WB_REG_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            res_valid,
  output logic [3:0]            res_ready,
  input  logic [4*DATA_W-1:0]   res_data,
  input  logic [4*TAG_W-1:0]    res_tag,
  input  logic [4*REG_W-1:0]    res_rd,
  input  logic                  wb_stall,
  output logic                  wb0_en,
  output logic                  wb1_en,
  output logic [DATA_W-1:0]     wb0_data,
  output logic [DATA_W-1:0]     wb1_data,
  output logic [TAG_W-1:0]      wb0_tag,
  output logic [TAG_W-1:0]      wb1_tag,
  output logic [REG_W-1:0]      wb0_rd,
  output logic [REG_W-1:0]      wb1_rd,
  output logic [1:0]            wb0_slot,
  output logic [1:0]            wb1_slot
);

  localparam int EW = DATA_W + TAG_W + REG_W;

  logic [NUM_SLOTS-1:0] full, empty, accept, push, pop, grant, bypass, elig;
  logic [EW-1:0]        in_entry  [NUM_SLOTS];
  logic [EW-1:0]        fifo_head [NUM_SLOTS];
  logic [EW-1:0]        head      [NUM_SLOTS];
  logic [EW-1:0]        g0_entry, g1_entry;
  logic [1:0]           rr_ptr, rr_next, g0, g1, s;
  logic                 g0_v, g1_v;

  assign res_ready = rst ? '0 : ~full;
  assign accept    = res_valid & res_ready;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign in_entry[i] = {res_data[i*DATA_W +: DATA_W],
                          res_tag[i*TAG_W +: TAG_W],
                          res_rd[i*REG_W +: REG_W]};

    wb_slot_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_entry[i]),
      .head  (fifo_head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Work out each slot's candidate head and whether it may compete this cycle.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
`ifdef WB_BYPASS_EN
      bypass[i] = empty[i] && accept[i];
`else
      bypass[i] = 1'b0;
`endif
      elig[i] = !empty[i] || bypass[i];
      head[i] = bypass[i] ? in_entry[i] : fifo_head[i];
    end
  end

  // Round-robin pick of up to two slots, same-rd drop, and push/pop steering.
  always_comb begin
    g0_v    = 1'b0;
    g1_v    = 1'b0;
    g0      = '0;
    g1      = '0;
    s       = '0;
    grant   = '0;
    rr_next = rr_ptr;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      s = rr_ptr + 2'(k);
      if (elig[s] && !wb_stall) begin
        if (!g0_v) begin
          g0_v = 1'b1;
          g0   = s;
        end else if (!g1_v) begin
          g1_v = 1'b1;
          g1   = s;
        end
      end
    end
    g0_entry = head[g0];
    g1_entry = head[g1];
    if (g1_v && (g1_entry[REG_W-1:0] == g0_entry[REG_W-1:0])) g1_v = 1'b0;
    if (g0_v) grant[g0] = 1'b1;
    if (g1_v) grant[g1] = 1'b1;
    if (g1_v)      rr_next = g1 + 2'd1;
    else if (g0_v) rr_next = g0 + 2'd1;
    push = accept & ~(bypass & grant);
    pop  = grant & ~bypass;
  end

  // Register the arbitration pointer and the two writeback ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      wb0_en   <= 1'b0;
      wb1_en   <= 1'b0;
      wb0_data <= '0;
      wb1_data <= '0;
      wb0_tag  <= '0;
      wb1_tag  <= '0;
      wb0_rd   <= '0;
      wb1_rd   <= '0;
      wb0_slot <= '0;
      wb1_slot <= '0;
    end else begin
      rr_ptr <= rr_next;
      wb0_en <= g0_v;
      wb1_en <= g1_v;
      if (g0_v) begin
        wb0_data <= g0_entry[EW-1 -: DATA_W];
        wb0_tag  <= g0_entry[REG_W +: TAG_W];
        wb0_rd   <= g0_entry[REG_W-1:0];
        wb0_slot <= g0;
      end
      if (g1_v) begin
        wb1_data <= g1_entry[EW-1 -: DATA_W];
        wb1_tag  <= g1_entry[REG_W +: TAG_W];
        wb1_rd   <= g1_entry[REG_W-1:0];
        wb1_slot <= g1;
      end
    end
  end

endmodule

// File: doc/wb_collect.md
Name: wb_collect

Overview:
- Result-return end of the issue path. ID hands instructions to the A0, A1, M and LS units with a destination register and a dest tag.
- This block collects the completed results from those four units and buffers them per slot.
- It round-robin arbitrates them onto two registered writeback ports. These ports drive the register file write ports and the tag-broadcast buses that ID uses for operand wakeup and forwarding.

Parameters:
- DATA_W, 32, result data width
- TAG_W, 6, dest tag width; matches the Rd tags issued by ID
- REG_W, 5, architectural register index width
- FIFO_DEPTH, 4, entries per slot FIFO; power of two, at least 2

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- res_valid  input  4  per-slot result valid; bit 0=A0, 1=A1, 2=M, 3=LS
- res_ready  output  4  per-slot accept
- res_data  input  4*DATA_W  per-slot result data
- res_tag  input  4*TAG_W  per-slot dest tag
- res_rd  input  4*REG_W  per-slot dest register
- wb_stall  input  1  downstream cannot take writebacks this cycle
- wb0_en, wb1_en  output  1 each  writeback port valid
- wb0_data, wb1_data  output  DATA_W each
- wb0_tag, wb1_tag  output  TAG_W each
- wb0_rd, wb1_rd  output  REG_W each
- wb0_slot, wb1_slot  output  2 each  source slot of the writeback

Behaviour:
- Reset (rst high at a clk edge):
  - all FIFOs empty; rr_ptr=0.
  - all wb*_en=0; all wb*_data/tag/rd/slot=0.
  - res_ready=0 while rst is high.
- Accept: res_ready[i] = !full[i]. A push occurs on res_valid[i] && res_ready[i]. A full FIFO never accepts, even in a cycle it pops.
- Arbitration each cycle when wb_stall=0:
  - scan slots in order rr_ptr, rr_ptr+1, ... mod 4.
  - first non-empty slot -> grant0; next non-empty slot -> grant1.
  - if grant1's head rd equals grant0's head rd, grant1 is dropped this cycle (preserves in-order register update).
  - rr_ptr <= (last granted slot + 1) mod 4. Unchanged if nothing is granted.
- Pop: granted FIFOs pop their head at the clk edge.
- Outputs are registered:
  - grant0's head -> wb0_*, wb0_en=1.
  - grant1's head -> wb1_*, wb1_en=1.
  - an ungranted port has en=0; its data/tag/rd/slot hold their previous value.
- wb_stall=1: no grants and no pops; wb0_en=wb1_en=0 on the next cycle. Pushes continue.
- Latency: a result pushed in cycle N (FIFO empty, no contention) appears on wb0 in cycle N+2.
- Ordering: strict FIFO within a slot. No ordering guarantee across slots except the same-rd rule above.
- Empty: with all FIFOs empty, both en=0.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH)+1 bits. full = MSBs differ and lower bits are equal.
- rst mid-operation: all buffered results are discarded, with no writeback; outputs clear on the same edge.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - a slot whose FIFO is empty and that pushes this cycle is arbitration-eligible with the incoming result as its head.
  - if granted, the result is not written into the FIFO; latency becomes 1 cycle (wb in N+1).
  - same-rd and stall rules apply unchanged.
- Undefined: incoming results are arbitrated only after they are stored (2-cycle latency).

Decomposition:
- Package wb_pkg holds:
  - NUM_SLOTS=4
  - slot constants SLOT_A0=0, SLOT_A1=1, SLOT_M=2, SLOT_LS=3
  - typedef wb_entry_t as a packed struct {data, tag, rd}, parameterized via package localparams matching the defaults
- Sub-module wb_slot_fifo: single-slot synchronous FIFO (push, pop, head, full, empty), instantiated 4 times.
- Arbiter and output registers live in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with res_valid=4'hF -> res_ready=0, wb0_en=wb1_en=0; after release, res_ready=4'hF.
- Single result: A0 pushes data=32'hDEADBEEF, tag=6'd5, rd=5'd3 in cycle N -> wb0_en=1 in N+2 with those values and wb0_slot=0, wb1_en=0. With WB_BYPASS_EN, the same appears in N+1.
- Fairness: all four slots push one result each in the same cycle, rr_ptr=0 -> wb0/wb1 carry slots 0/1, then slots 2/3 the next cycle; rr_ptr ends at 0.
- Same-rd conflict: A1 and M both head with rd=7 -> only the A1 result writes back first; M appears on wb0 the following cycle.
- Full and stall:
  - hold wb_stall=1 and push 5 LS results -> res_ready[3] drops after 4 accepts; the 5th is held by the producer.
  - release stall -> 5 writebacks in FIFO order, tags 1..5, no loss or duplication.
